// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI initiator sequencer.
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } pci_state_e;

    localparam logic [3:0] MEM_READ  = 4'h6;
    localparam logic [3:0] MEM_WRITE = 4'h7;

    localparam int DEVSEL_TO = 5;

endpackage

// File: rtl/pci_master.sv
// PCI initiator: requests the bus, runs one burst, and terminates on completion,
// target stop, or master abort.
//
// state | meaning
// IDLE  | bus released, waiting for start with len != 0
// REQ   | req raised, waiting for gnt with an idle bus
// ADDR  | address phase, frame asserted, devsel timer loaded
// DATA  | data phases, irdy asserted, frame released on the last phase
// TURN  | drivers parked deasserted for one cycle, done pulse
module pci_master #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int DEVSEL_TO = pci_pkg::DEVSEL_TO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              retry,
    output logic              abort,
    output logic              req,
    input  logic              gnt,
    input  logic              frame_in,
    input  logic              irdy_in,
    input  logic              trdy,
    input  logic              devsel,
    input  logic              stop,
    input  logic [DATA_W-1:0] ad_in,
    output logic              frame_out,
    output logic              irdy_out,
    output logic              frame_oe,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic [3:0]        cbe_out
);
    import pci_pkg::*;

    localparam int TW = $clog2(DEVSEL_TO + 1);

    pci_state_e        state;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] ad_q;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  rem_next;
    logic [TW-1:0]     dsel_tmr;
    logic              devsel_seen;
    logic              is_write;
    logic              abort_now;
    logic              stop_now;
    logic              phase_ok;
    logic              last_done;

    always_comb begin
        is_write  = cmd_q[0];
        abort_now = (state == ST_DATA) && devsel && !devsel_seen && (dsel_tmr <= TW'(1));
        phase_ok  = (state == ST_DATA) && !trdy && !abort_now;
        stop_now  = (state == ST_DATA) && !stop && !abort_now;
        rem_next  = (phase_ok && remaining != '0) ? remaining - LEN_W'(1) : remaining;
        last_done = phase_ok && (remaining == LEN_W'(1));
    end

    // Write data passes straight through so the word after an ack is on the bus next cycle.
    assign wdata_ack = phase_ok && is_write;
    assign ad_out    = (state == ST_DATA && is_write) ? wdata : ad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            remaining   <= '0;
            dsel_tmr    <= '0;
            devsel_seen <= 1'b0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            retry       <= 1'b0;
            abort       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            frame_out   <= 1'b1;
            irdy_out    <= 1'b1;
            frame_oe    <= 1'b0;
            ad_oe       <= 1'b0;
            ad_q        <= '0;
            cbe_out     <= 4'hF;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            retry    <= 1'b0;
            abort    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    frame_oe  <= 1'b0;
                    ad_oe     <= 1'b0;
                    frame_out <= 1'b1;
                    irdy_out  <= 1'b1;
                    cbe_out   <= 4'hF;
                    if (start && len != '0) begin
                        cmd_q     <= cmd;
                        addr_q    <= addr;
                        remaining <= len;
                        req       <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt && frame_in && irdy_in) begin
                        req         <= 1'b0;
                        frame_oe    <= 1'b1;
                        frame_out   <= 1'b0;
                        irdy_out    <= 1'b1;
                        ad_oe       <= 1'b1;
                        ad_q        <= addr_q;
                        cbe_out     <= cmd_q;
                        dsel_tmr    <= TW'(DEVSEL_TO);
                        devsel_seen <= 1'b0;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    irdy_out  <= 1'b0;
                    cbe_out   <= 4'h0;
                    frame_out <= (remaining <= LEN_W'(1));
                    ad_oe     <= is_write;
                    dsel_tmr  <= dsel_tmr - TW'(1);
                    if (!devsel) devsel_seen <= 1'b1;
                    state     <= ST_DATA;
                end
                ST_DATA: begin
                    if (dsel_tmr != '0) dsel_tmr <= dsel_tmr - TW'(1);
                    if (!devsel) devsel_seen <= 1'b1;
                    remaining <= rem_next;
                    if (phase_ok && !is_write) begin
                        rd_valid <= 1'b1;
                        rd_data  <= ad_in;
                    end
                    if (abort_now || stop_now || last_done) begin
                        frame_out <= 1'b1;
                        irdy_out  <= 1'b1;
                        ad_oe     <= 1'b0;
                        cbe_out   <= 4'hF;
                        done      <= 1'b1;
                        abort     <= abort_now;
                        retry     <= stop_now;
                        state     <= ST_TURN;
                    end else begin
                        frame_out <= (rem_next <= LEN_W'(1));
                    end
                end
                ST_TURN: begin
                    frame_oe <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pci_master.md
# pci_master

PCI initiator sequencer that sits directly downstream of the bus arbiter: it raises one `request` line, consumes the matching `grant` bit, and runs a single burst transaction on the shared bus. It issues the address phase, counts data phases, handles target wait states, and terminates on completion, target stop, or master abort. One instance sits in each bus agent.

## Interface
- `DATA_W`, 32: width of AD bus and local data.
- `LEN_W`, 4: width of burst length, which allows up to 15 data phases.
- `DEVSEL_TO`, 5: cycles after the address phase without `devsel` before a master abort.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  local command strobe; sampled only in IDLE.
- `cmd`  in  4  PCI command; `cmd[0]`=1 means write.
- `addr`  in  DATA_W  start address.
- `len`  in  LEN_W  number of data phases; 0 means the command is ignored.
- `wdata`  in  DATA_W  current write word.
- `wdata_ack`  out  1  pulse; the current write word was transferred, so present the next one.
- `rd_data`  out  DATA_W  captured read word.
- `rd_valid`  out  1  pulse qualifying `rd_data`.
- `busy`  out  1  high from the cycle after an accepted start through TURN.
- `done`  out  1  one-cycle pulse in TURN.
- `retry`  out  1  valid with `done`; the target terminated with stop.
- `abort`  out  1  valid with `done`; master abort (no devsel).
- `req`  out  1  to the arbiter `request` bit; active-high.
- `gnt`  in  1  from the arbiter `grant` bit; active-high.
- `frame_in`, `irdy_in`  in  1  bus levels, raw PCI (1 = deasserted).
- `trdy`, `devsel`, `stop`  in  1  target signals, raw PCI (1 = deasserted).
- `ad_in`  in  DATA_W  bus AD level.
- `frame_out`, `irdy_out`  out  1  driven levels, raw PCI.
- `frame_oe`  out  1  enable for the frame and irdy drivers.
- `ad_out`  out  DATA_W; `ad_oe` out 1; `cbe_out` out 4.

## Operation
- States: IDLE, REQ, ADDR, DATA, TURN.
- IDLE → REQ when `start`=1 and `len`≠0. On this transition, latch `cmd`, `addr`, and `len` into the remaining-phase counter.
- REQ: `req`=1. The block moves to ADDR when `gnt`=1 and the bus is idle (`frame_in`=1 and `irdy_in`=1). Otherwise it holds in REQ, including when `gnt` toggles.
- ADDR, exactly one cycle:
  - `req`=0, `frame_oe`=1, `frame_out`=0, `irdy_out`=1.
  - `ad_oe`=1, `ad_out`=addr, `cbe_out`=cmd.
  - Clear the devsel timer. Go to DATA.
- DATA:
  - `irdy_out`=0 and `cbe_out`=4'h0.
  - `frame_out`=0 while remaining>1; `frame_out`=1 when remaining==1, which marks the last phase.
  - Write: `ad_oe`=1 and `ad_out`=wdata.
  - Read: `ad_oe`=0. The first DATA cycle serves as turnaround.
  - A phase completes on a cycle with `trdy`=0. That cycle gives a read a `rd_valid` pulse with `rd_data`=ad_in, and gives a write a `wdata_ack` pulse. Then decrement remaining.
- Termination, evaluated each DATA cycle in priority order:
  1. Master abort: timer reaches DEVSEL_TO with `devsel` still 1. Set `abort`=1 and go to TURN.
  2. `stop`=0: set `retry`=1 and go to TURN. If `trdy`=0 in the same cycle, that phase still completes (disconnect with data).
  3. Completion on the last phase: go to TURN.
- TURN, one cycle:
  - `frame_oe`=1, `frame_out`=1, `irdy_out`=1, `ad_oe`=0.
  - `done`=1 with `retry`/`abort` valid. Then go to IDLE.
- IDLE: `frame_oe`=0. The block never drives the bus, even if `gnt` is parked on it.
- `gnt` removed during ADDR, DATA, or TURN: no effect. The latency timer is out of scope.

## Timing
- Reset values: `req`=0, `frame_out`=1, `irdy_out`=1, `frame_oe`=0, `ad_oe`=0, `ad_out`=0, `cbe_out`=4'hF, `rd_data`=0. All pulse and status outputs are 0, and the state is IDLE.
- `rst` mid-transaction takes effect immediately. All drivers are released and no `done` is issued.
- Latency:
  - start → `req`: 1 cycle.
  - grant-and-idle → ADDR: 1 cycle.
  - ADDR → first DATA: 1 cycle.
  - Last completed phase → TURN (`done`): 1 cycle.
- The counter is LEN_W bits and never wraps; it stops at 0.

## Structure
- Shared package `pci_pkg`:
  - state enum;
  - command codes (MEM_READ 4'h6, MEM_WRITE 4'h7);
  - constant DEVSEL_TO.
- No sub-module. The phase counter and devsel timer stay inline.

## Test plan
- Write, len=3, `gnt` in the cycle after `req`, `devsel`/`trdy`=0 from the first DATA cycle → three `wdata_ack` pulses, `frame_out`=1 on the third phase, `done`=1 with retry=0 and abort=0.
- Read, len=2, `trdy` held 1 for 2 wait cycles → `rd_valid` fires only on `trdy`=0 cycles, and `rd_data` matches `ad_in`=32'hA5A5_0001, then 32'hA5A5_0002.
- `devsel` never asserted → `abort`=1 with `done`, exactly DEVSEL_TO cycles after ADDR.
- `stop`=0 with `trdy`=0 on phase 2 of len=4 → two phases transferred, then `done` with `retry`=1.
- `gnt`=1 while `frame_in`=0 → stays in REQ; enters ADDR 1 cycle after `frame_in`/`irdy_in` both return to 1.
- `rst` pulse mid-DATA → `frame_oe`=0, `ad_oe`=0, `req`=0 immediately, and no `done`; `start` with len=0 → `busy` stays 0.
